// File: rtl/sw_pkg.sv
// Shared types for the Smith-Waterman solver array and its traceback unit.
// The arrow encoding here is the one the solver cells write into the matrix.
package sw_pkg;

  localparam int DIM   = 16;
  localparam int VAL_W = 8;

  typedef enum logic [1:0] {
    ARR_STOP = 2'b00,
    ARR_UP   = 2'b01,
    ARR_LEFT = 2'b10,
    ARR_DIAG = 2'b11
  } arrow_e;

  typedef enum logic [2:0] {
    TB_IDLE,
    TB_FETCH,
    TB_WAIT,
    TB_EMIT,
    TB_DONE
  } tb_state_e;

endpackage

// File: rtl/sw_tb_next.sv
// Traceback step: next coordinates plus stop / out-of-matrix flags for
// one visited cell.
module sw_tb_next #(
  parameter int VAL_W = sw_pkg::VAL_W
) (
  input  sw_pkg::arrow_e   arrow_i,
  input  logic [VAL_W-1:0] val_i,
  input  logic [3:0]       row_i,
  input  logic [3:0]       col_i,
  output logic [3:0]       nxt_row_o,
  output logic [3:0]       nxt_col_o,
  output logic             stop_o,
  output logic             bnd_err_o
);
  import sw_pkg::*;

  // A stop cell never attempts a move, so it cannot be a boundary error.
  always_comb begin
    stop_o    = (arrow_i == ARR_STOP) || (val_i == '0);
    bnd_err_o = 1'b0;
    nxt_row_o = row_i;
    nxt_col_o = col_i;
    if (!stop_o) begin
      unique case (arrow_i)
        ARR_UP: begin
          if (row_i == 4'd0) bnd_err_o = 1'b1;
          else nxt_row_o = row_i - 4'd1;
        end
        ARR_LEFT: begin
          if (col_i == 4'd0) bnd_err_o = 1'b1;
          else nxt_col_o = col_i - 4'd1;
        end
        ARR_DIAG: begin
          if (row_i == 4'd0 || col_i == 4'd0) begin
            bnd_err_o = 1'b1;
          end else begin
            nxt_row_o = row_i - 4'd1;
            nxt_col_o = col_i - 4'd1;
          end
        end
        default: bnd_err_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/sw_traceback.sv
// Smith-Waterman traceback: walks arrows back from the max-score cell and
// streams one op per visited cell over a valid/ready handshake.
module sw_traceback #(
  parameter int DIM   = sw_pkg::DIM,
  parameter int VAL_W = sw_pkg::VAL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       start_row,
  input  logic [3:0]       start_col,
  output logic             mem_rd,
  output logic [7:0]       mem_addr,
  input  logic [1:0]       mem_arrow,
  input  logic [VAL_W-1:0] mem_val,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       op_code,
  output logic [3:0]       op_row,
  output logic [3:0]       op_col,
  output logic [VAL_W-1:0] op_val,
  output logic             op_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       path_len
);
  import sw_pkg::*;

  // Longest legal path in a DIM x DIM matrix.
  localparam logic [4:0] LEN_MAX = 5'(2 * DIM - 1);

  tb_state_e        state_q, state_d;
  logic [3:0]       cur_row_q, cur_row_d;
  logic [3:0]       cur_col_q, cur_col_d;
  logic [3:0]       nxt_row_q, nxt_row_d;
  logic [3:0]       nxt_col_q, nxt_col_d;
  arrow_e           op_code_q, op_code_d;
  logic [3:0]       op_row_q, op_row_d;
  logic [3:0]       op_col_q, op_col_d;
  logic [VAL_W-1:0] op_val_q, op_val_d;
  logic             op_last_q, op_last_d;
  logic             err_q, err_d;
  logic [4:0]       len_q, len_d;

  logic [3:0] step_row, step_col;
  logic       step_stop, step_bnd;

  sw_tb_next #(.VAL_W(VAL_W)) u_next (
    .arrow_i   (arrow_e'(mem_arrow)),
    .val_i     (mem_val),
    .row_i     (cur_row_q),
    .col_i     (cur_col_q),
    .nxt_row_o (step_row),
    .nxt_col_o (step_col),
    .stop_o    (step_stop),
    .bnd_err_o (step_bnd)
  );

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    nxt_row_d = nxt_row_q;
    nxt_col_d = nxt_col_q;
    op_code_d = op_code_q;
    op_row_d  = op_row_q;
    op_col_d  = op_col_q;
    op_val_d  = op_val_q;
    op_last_d = op_last_q;
    err_d     = err_q;
    len_d     = len_q;
    unique case (state_q)
      TB_IDLE: begin
        if (start) begin
          cur_row_d = start_row;
          cur_col_d = start_col;
          len_d     = '0;
          err_d     = 1'b0;
          state_d   = TB_FETCH;
        end
      end
      TB_FETCH: state_d = TB_WAIT;
      TB_WAIT: begin
        op_code_d = arrow_e'(mem_arrow);
        op_val_d  = mem_val;
        op_row_d  = cur_row_q;
        op_col_d  = cur_col_q;
        op_last_d = step_stop | step_bnd;
        nxt_row_d = step_row;
        nxt_col_d = step_col;
        err_d     = err_q | step_bnd;
        state_d   = TB_EMIT;
      end
      TB_EMIT: begin
        if (op_ready) begin
          if (len_q != LEN_MAX) len_d = len_q + 5'd1;
          if (op_last_q) begin
            state_d = TB_DONE;
          end else begin
            cur_row_d = nxt_row_q;
            cur_col_d = nxt_col_q;
            state_d   = TB_FETCH;
          end
        end
      end
      TB_DONE: state_d = TB_IDLE;
      default: state_d = TB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TB_IDLE;
      cur_row_q <= '0;
      cur_col_q <= '0;
      nxt_row_q <= '0;
      nxt_col_q <= '0;
      op_code_q <= ARR_STOP;
      op_row_q  <= '0;
      op_col_q  <= '0;
      op_val_q  <= '0;
      op_last_q <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      nxt_row_q <= nxt_row_d;
      nxt_col_q <= nxt_col_d;
      op_code_q <= op_code_d;
      op_row_q  <= op_row_d;
      op_col_q  <= op_col_d;
      op_val_q  <= op_val_d;
      op_last_q <= op_last_d;
      err_q     <= err_d;
      len_q     <= len_d;
    end
  end

  assign mem_rd   = (state_q == TB_FETCH);
  assign mem_addr = mem_rd ? {cur_row_q, cur_col_q} : 8'd0;
  assign op_valid = (state_q == TB_EMIT);
  assign op_code  = op_code_q;
  assign op_row   = op_row_q;
  assign op_col   = op_col_q;
  assign op_val   = op_val_q;
  assign op_last  = op_last_q;
  assign busy     = (state_q != TB_IDLE);
  assign done     = (state_q == TB_DONE);
  assign err      = err_q;
  assign path_len = len_q;

endmodule

// File: tb/tb_sw_traceback.sv
// Bench for sw_traceback: table of paths plus backpressure, busy-start
// and mid-path reset sequences, checked through an op scoreboard.
module tb_sw_traceback;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] start_row, start_col;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [1:0] mem_arrow = 2'b00;
  logic [7:0] mem_val = 8'd0;
  logic       op_valid, op_ready;
  logic [1:0] op_code;
  logic [3:0] op_row, op_col;
  logic [7:0] op_val;
  logic       op_last, busy, done, err;
  logic [4:0] path_len;

  always #5 clk = ~clk;

  sw_traceback #(.DIM(16), .VAL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .start_row(start_row), .start_col(start_col),
    .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_arrow(mem_arrow), .mem_val(mem_val),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_row(op_row), .op_col(op_col), .op_val(op_val),
    .op_last(op_last), .busy(busy), .done(done), .err(err),
    .path_len(path_len)
  );

  logic [1:0] am [256];
  logic [7:0] vm [256];

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_arrow <= am[mem_addr];
      mem_val   <= vm[mem_addr];
    end
  end

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] val;
    logic       last;
  } op_t;

  typedef struct {
    logic [3:0] sr;
    logic [3:0] sc;
    logic [1:0] arr [4];
    logic [7:0] val [4];
    int         n;
    logic [4:0] len;
    logic       err;
  } vec_t;

  op_t  exp_q [$];
  op_t  mon_e;
  vec_t vecs [7];
  vec_t vrst;
  int   n_vec = 0, n_err = 0, rd_cnt = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd) rd_cnt++;
      if (done) done_cnt++;
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          chk("op_extra", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("op", 32'({op_code, op_row, op_col, op_val, op_last}),
              32'(mon_e));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, 32'({mem_rd, mem_addr, op_valid, op_code, op_row,
                          op_col, op_last}), 32'd0);
    chk({tag, "_b"}, 32'({op_val, busy, done, err, path_len}), 32'd0);
  endtask

  task automatic load(input vec_t v);
    logic [3:0] r, c;
    op_t o;
    for (int i = 0; i < 256; i++) begin
      am[i] = 2'b00;
      vm[i] = 8'd0;
    end
    r = v.sr;
    c = v.sc;
    for (int k = 0; k < v.n; k++) begin
      am[{r, c}] = v.arr[k];
      vm[{r, c}] = v.val[k];
      o.code = v.arr[k];
      o.row  = r;
      o.col  = c;
      o.val  = v.val[k];
      o.last = (k == v.n - 1);
      exp_q.push_back(o);
      case (v.arr[k])
        2'b01: r = r - 4'd1;
        2'b10: c = c - 4'd1;
        2'b11: begin r = r - 4'd1; c = c - 4'd1; end
        default: ;
      endcase
    end
  endtask

  task automatic kick(input logic [3:0] r, input logic [3:0] c);
    @(posedge clk); #1;
    start = 1'b1;
    start_row = r;
    start_col = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_check(input vec_t v, input int rd0, input int d0,
                              input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_len"}, 32'(path_len), 32'(v.len));
    chk({tag, "_err"}, 32'(err), 32'(v.err));
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_rd"}, 32'(rd_cnt - rd0), 32'(v.n));
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int rd0, d0, lat, seen;
    logic [18:0] snap;
    bit stable;

    reset = 1'b0;
    start = 1'b0;
    start_row = 4'd0;
    start_col = 4'd0;
    op_ready = 1'b1;

    vecs[0] = '{4'd3, 4'd3, '{2'b11, 2'b11, 2'b11, 2'b00},
                '{8'd6, 8'd4, 8'd2, 8'd1}, 4, 5'd4, 1'b0};
    vecs[1] = '{4'd2, 4'd1, '{2'b01, 2'b10, 2'b00, 2'b00},
                '{8'd5, 8'd5, 8'd5, 8'd0}, 3, 5'd3, 1'b0};
    vecs[2] = '{4'd0, 4'd5, '{2'b01, 2'b00, 2'b00, 2'b00},
                '{8'd3, 8'd0, 8'd0, 8'd0}, 1, 5'd1, 1'b1};
    vecs[3] = '{4'd5, 4'd5, '{2'b11, 2'b00, 2'b00, 2'b00},
                '{8'd0, 8'd0, 8'd0, 8'd0}, 1, 5'd1, 1'b0};
    vecs[4] = '{4'd4, 4'd2, '{2'b10, 2'b10, 2'b10, 2'b00},
                '{8'd3, 8'd3, 8'd3, 8'd0}, 3, 5'd3, 1'b1};
    vecs[5] = '{4'd6, 4'd0, '{2'b11, 2'b00, 2'b00, 2'b00},
                '{8'd7, 8'd0, 8'd0, 8'd0}, 1, 5'd1, 1'b1};
    vecs[6] = '{4'd15, 4'd15, '{2'b01, 2'b11, 2'b00, 2'b00},
                '{8'd9, 8'd8, 8'd7, 8'd0}, 3, 5'd3, 1'b0};
    vrst    = '{4'd1, 4'd1, '{2'b11, 2'b00, 2'b00, 2'b00},
                '{8'd2, 8'd1, 8'd0, 8'd0}, 2, 5'd2, 1'b0};

    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      rd0 = rd_cnt;
      d0 = done_cnt;
      load(vecs[i]);
      kick(vecs[i].sr, vecs[i].sc);
      finish_check(vecs[i], rd0, d0, $sformatf("vec%0d", i));
    end

    // first EMIT held off for 5 cycles
    rd0 = rd_cnt;
    d0 = done_cnt;
    load(vecs[0]);
    op_ready = 1'b0;
    kick(vecs[0].sr, vecs[0].sc);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (op_valid) break;
    end
    chk("bp_latency", 32'(lat), 32'd3);
    snap = {op_code, op_row, op_col, op_val, op_last};
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({op_code, op_row, op_col, op_val, op_last} !== snap || !op_valid)
        stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_rd", 32'(rd_cnt - rd0), 32'd1);
    @(posedge clk); #1;
    op_ready = 1'b1;
    finish_check(vecs[0], rd0, d0, "bp");

    // start while busy must be ignored
    rd0 = rd_cnt;
    d0 = done_cnt;
    load(vecs[1]);
    am[{4'd7, 4'd7}] = 2'b00;
    vm[{4'd7, 4'd7}] = 8'd9;
    kick(vecs[1].sr, vecs[1].sc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_cnt - rd0 >= 2) break;
    end
    kick(4'd7, 4'd7);
    finish_check(vecs[1], rd0, d0, "busy");

    // reset during second WAIT
    load(vecs[0]);
    kick(vecs[0].sr, vecs[0].sc);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_rd) seen++;
      if (seen == 2) break;
    end
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk_zero("midrst");
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    rd0 = rd_cnt;
    d0 = done_cnt;
    load(vrst);
    kick(vrst.sr, vrst.sc);
    finish_check(vrst, rd0, d0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sw_traceback.md
SW_TRACEBACK -- requirements
Module: sw_traceback

Interface
REQ-001 SHALL have parameter DIM, default 16, matrix dimension (rows = cols = DIM).
REQ-002 SHALL have parameter VAL_W, default 8, score width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a traceback; honoured only in IDLE.
REQ-006 SHALL have ports start_row, start_col  input  4 each  coordinates of the max-score cell.
REQ-007 SHALL have port mem_rd  output  1  read strobe to the score/arrow matrix memory.
REQ-008 SHALL have port mem_addr  output  8  {row[3:0], col[3:0]}.
REQ-009 SHALL have ports mem_arrow  input  2  and mem_val  input  VAL_W, valid exactly 1 cycle after mem_rd.
REQ-010 SHALL have ports op_valid  output  1,  op_ready  input  1,  op_code  output  2  (arrow of visited cell).
REQ-011 SHALL have ports op_row, op_col  output  4 each,  op_val  output  VAL_W,  op_last  output  1.
REQ-012 SHALL have ports busy  output  1,  done  output  1  (one-cycle pulse),  err  output  1,  path_len  output  5.

Function
REQ-013 SHALL implement FSM IDLE -> FETCH -> WAIT -> EMIT -> (FETCH | DONE) -> IDLE.
REQ-014 IDLE: start=1 latches start_row/col into cur_row/cur_col, clears path_len and err, next state FETCH.
REQ-015 FETCH: mem_rd=1 for exactly one cycle, mem_addr={cur_row,cur_col}; next state WAIT.
REQ-016 WAIT: registers mem_arrow, mem_val, cur_row, cur_col into the op_* registers; next state EMIT.
REQ-017 EMIT: op_valid=1; op_* held stable until the op_valid&&op_ready handshake; no handshake means stay in EMIT.
REQ-018 Arrow decode: 00 stop, 01 up (row-1), 10 left (col-1), 11 diag (row-1, col-1).
REQ-019 op_last=1 when arrow=00, or mem_val=0, or the move leaves the matrix: up at row 0, left at col 0, diag at row 0 or col 0.
REQ-020 The out-of-matrix case in REQ-019 SHALL also set err=1, which holds until the next accepted start.
REQ-021 On handshake with op_last=0: cur coordinates update per the arrow, path_len increments, next state FETCH.
REQ-022 On handshake with op_last=1: path_len increments, next state DONE.
REQ-023 DONE lasts one cycle with done=1; next state IDLE.
REQ-024 path_len SHALL saturate at 31 (maximum legal path in 16x16 is 31 cells).
REQ-025 Minimum throughput is 3 cycles per cell (FETCH, WAIT, EMIT with op_ready=1); start-to-first-op_valid is 3 cycles.
REQ-026 busy=1 in every state except IDLE; start while busy SHALL be ignored without side effects.
REQ-027 Coordinate arithmetic SHALL be unsigned 4-bit; no decrement is performed when the stop/boundary condition holds, so no wrap-around.

Reset
REQ-028 reset low SHALL asynchronously force IDLE with mem_rd=0, mem_addr=0, op_valid=0, op_code=0, op_row=0, op_col=0, op_val=0, op_last=0, busy=0, done=0, err=0, path_len=0.
REQ-029 reset asserted mid-traceback SHALL abandon the path; no done pulse; the first start after release begins a fresh traceback.

Structure
REQ-030 Shared package sw_pkg SHALL hold DIM, VAL_W, arrow enum (ARR_STOP, ARR_UP, ARR_LEFT, ARR_DIAG = 00/01/10/11) and the traceback state enum.
REQ-031 The arrow enum SHALL be the same type the solver cells use to encode arrow.
REQ-032 One combinational sub-module sw_tb_next SHALL compute next row/col, stop and boundary-error flags from (arrow, val, row, col).

Verification
REQ-033 Diagonal run: start (3,3), cells (3,3),(2,2),(1,1) arrow 11 val 6/4/2, (0,0) arrow 00 -> 4 ops, op_last on (0,0), path_len=4, err=0, done one pulse.
REQ-034 Mixed path: start (2,1); (2,1)=01, (1,1)=10, (1,0)=00 -> ops at (2,1),(1,1),(1,0); op_codes 01,10,00.
REQ-035 Boundary: start (0,5) arrow 01 val 3 -> single op with op_last=1, err=1, path_len=1.
REQ-036 Backpressure: op_ready low 5 cycles during first EMIT -> op_* stable, no extra mem_rd, same final result as with op_ready high.
REQ-037 Reset mid-path: assert reset during second WAIT -> all outputs 0 next cycle, no done; later start (1,1) completes normally.
REQ-038 Start while busy: pulse start with (7,7) mid-path -> ignored; original path and path_len unchanged.
